// File: rtl/seq_divider.sv
// Sequential restoring divider: one quotient bit per clock, valid/ready on both sides.
// Define SEQ_DIVIDER_SIGNED_EN to treat operands and results as two's complement.
module seq_divider #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;
    logic             dbz_q;

    // Datapath: rem_q is the partial remainder, dvd_q shifts dividend bits out
    // at the top while quotient bits shift in at the bottom.
    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [CW-1:0]    cnt_q;

    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   trial;
    logic             fits;
    logic [WIDTH:0]   rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rmd_fix;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dsr_mag;
    logic             last_step;

`ifdef SEQ_DIVIDER_SIGNED_EN
    logic neg_quo_q;
    logic neg_rem_q;
`endif

    // The restored remainder is always below the divisor, so its top bit is
    // only ever a borrow indicator during the trial step.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        shifted   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        trial     = shifted - {1'b0, dsr_q};
        fits      = ~trial[WIDTH];
        rem_d     = fits ? trial : shifted;
        quo_d     = {dvd_q[WIDTH-2:0], fits};
        last_step = (cnt_q == CW'(WIDTH - 1));
`ifdef SEQ_DIVIDER_SIGNED_EN
        dvd_mag   = dividend[WIDTH-1] ? -dividend : dividend;
        dsr_mag   = divisor[WIDTH-1]  ? -divisor  : divisor;
        quo_fix   = neg_quo_q ? -quo_d : quo_d;
        rmd_fix   = neg_rem_q ? -rem_d[WIDTH-1:0] : rem_d[WIDTH-1:0];
`else
        dvd_mag   = dividend;
        dsr_mag   = divisor;
        quo_fix   = quo_d;
        rmd_fix   = rem_d[WIDTH-1:0];
`endif
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            quo_q       <= '0;
            rmd_q       <= '0;
            dbz_q       <= 1'b0;
            rem_q       <= '0;
            dvd_q       <= '0;
            dsr_q       <= '0;
            cnt_q       <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            neg_quo_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        in_ready_q <= 1'b0;
                        rem_q      <= '0;
                        cnt_q      <= '0;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        neg_quo_q  <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_q  <= dividend[WIDTH-1];
`endif
                        if (divisor == '0) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            quo_q       <= '1;
                            rmd_q       <= dividend;
                            dbz_q       <= 1'b1;
                            dvd_q       <= dividend;
                            dsr_q       <= '0;
                        end else begin
                            state_q <= CALC;
                            dvd_q   <= dvd_mag;
                            dsr_q   <= dsr_mag;
                        end
                    end
                end
                CALC: begin
                    rem_q <= rem_d;
                    dvd_q <= quo_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_step) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        quo_q       <= quo_fix;
                        rmd_q       <= rmd_fix;
                        dbz_q       <= 1'b0;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=8); expectations come from a behavioural model.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] dividend = '0;
    logic [7:0] divisor = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] quotient;
    logic [7:0] remainder;
    logic       div_by_zero;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
    } exp_t;

    exp_t sb[$];

    seq_divider #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa;
        int   sd;
        int   qq;
        int   rr;
        if (b == 8'd0) begin
            e.q   = 8'hFF;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 1;
        end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
            sa = $signed(a);
            sd = $signed(b);
`else
            sa = int'(a);
            sd = int'(b);
`endif
            qq    = sa / sd;
            rr    = sa % sd;
            e.q   = qq[7:0];
            e.r   = rr[7:0];
            e.dbz = 1'b0;
            e.lat = 9;
        end
        return e;
    endfunction

    // Entered and left at a negedge. hold = cycles out_ready stays low once valid.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input int hold);
        exp_t       e;
        int         lat;
        int         guard;
        logic [7:0] q0;
        logic [7:0] r0;
        logic       z0;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("wait_in_ready", {31'd0, in_ready}, 32'd1);
        dividend  = a;
        divisor   = b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        sb.push_back(model(a, b));
        @(posedge clk);
        @(negedge clk);
        // Junk on the operand bus while busy must be ignored.
        dividend = 8'($urandom);
        divisor  = 8'($urandom);
        lat = 1;
        while (!out_valid && lat < 100) begin
            check("busy_in_ready", {31'd0, in_ready}, 32'd0);
            @(negedge clk);
            lat++;
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("done_in_ready", {31'd0, in_ready}, 32'd0);
        q0 = quotient;
        r0 = remainder;
        z0 = div_by_zero;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_in_ready", {31'd0, in_ready}, 32'd0);
            check("hold_stable", {15'd0, quotient, r0 ^ remainder, z0 ^ div_by_zero},
                  {15'd0, q0, 8'd0, 1'b0});
        end
        out_ready = 1'b1;
        check("quotient", quotient, e.q);
        check("remainder", remainder, e.r);
        check("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dbz});
        @(negedge clk);
        in_valid = 1'b0;
        check("post_valid", {31'd0, out_valid}, 32'd0);
        check("post_in_ready", {31'd0, in_ready}, 32'd1);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        repeat (3) @(negedge clk);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_outputs", {15'd0, quotient, remainder, div_by_zero}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

`ifdef SEQ_DIVIDER_SIGNED_EN
        do_op(8'hF9, 8'd2, 0);
        do_op(8'h80, 8'hFF, 0);
        do_op(8'd7, 8'hFE, 0);
        do_op(8'h85, 8'd0, 2);
`else
        do_op(8'd200, 8'd7, 0);
        do_op(8'd255, 8'd1, 0);
        do_op(8'd3, 8'd200, 0);
        do_op(8'd5, 8'd0, 0);
        do_op(8'd100, 8'd9, 6);
`endif

        // Reset mid-CALC: accept 200/7, then assert rst for the 4th CALC edge.
        dividend  = 8'd200;
        divisor   = 8'd7;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_outputs", {15'd0, quotient, remainder, div_by_zero}, 32'd0);
        do_op(8'd50, 8'd5, 0);

        for (int i = 0; i < 8; i++) begin
            ra = 8'($urandom);
            rb = (i == 3) ? 8'd0 : 8'($urandom_range(0, 255));
            do_op(ra, rb, i % 3);
        end

        check("scoreboard_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got running, expected done");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, setting operand and result width in bits (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: dividend and divisor are valid.
REQ-005 The block SHALL have port in_ready, output, 1 bit: block can accept operands.
REQ-006 The block SHALL have port dividend, input, WIDTH bits: numerator.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: denominator.
REQ-008 The block SHALL have port out_valid, output, 1 bit: the results below are valid.
REQ-009 The block SHALL have port out_ready, input, 1 bit: downstream accepts the result.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: division result.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: division remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: the current result came from a zero divisor.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, CALC and DONE.
REQ-014 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-015 Operands SHALL be accepted on a clock edge with in_valid=1 and in_ready=1; they are captured into internal registers at that edge.
REQ-016 The block SHALL ignore operand inputs at all other times.
REQ-017 On acceptance with divisor!=0, the FSM SHALL go IDLE->CALC.
REQ-018 CALC SHALL do restoring division, one quotient bit per cycle, MSB first: shift the partial remainder left by one bit, bring in the next dividend bit, trial-subtract the divisor, then keep or restore.
REQ-019 The partial remainder SHALL be WIDTH+1 bits wide, so a trial subtraction never overflows.
REQ-020 After exactly WIDTH CALC cycles, the FSM SHALL go CALC->DONE.
REQ-021 out_valid SHALL first be high WIDTH+1 edges after the accepting edge.
REQ-022 On acceptance with divisor==0, the FSM SHALL go IDLE->DONE directly, with quotient=all ones, remainder=dividend and div_by_zero=1.
REQ-023 In that case, out_valid SHALL be high 1 edge after acceptance.
REQ-024 div_by_zero SHALL be 0 for every non-zero divisor.
REQ-025 In DONE, quotient, remainder and div_by_zero SHALL be stable while out_ready=0, for any number of cycles.
REQ-026 DONE->IDLE SHALL occur on an edge with out_ready=1, and in_ready SHALL be 1 in the following cycle.
REQ-027 There SHALL be no input/output overlap: a new operand set is never accepted in the same cycle as a result handoff.
REQ-028 Outside DONE, quotient, remainder and div_by_zero SHALL hold their last values; their contents there are don't-care for consumers.
REQ-029 A new acceptance SHALL fully re-initialise all datapath registers, with no dependence on earlier operations.

Reset
REQ-030 While rst=1 at an edge, the FSM SHALL go to IDLE from any state, including mid-CALC or in DONE with out_ready=0; an in-flight operation is discarded.
REQ-031 Reset values SHALL be: in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and the internal counter and partial remainder zeroed.
REQ-032 rst SHALL take priority over in_valid and out_ready in the same cycle.

Configuration
REQ-033 Macro SEQ_DIVIDER_SIGNED_EN, when defined, SHALL make operands and results two's complement.
REQ-034 When SEQ_DIVIDER_SIGNED_EN is defined:
  - operand magnitudes are divided;
  - the quotient is negated if the operand signs differ, truncating toward zero;
  - the remainder takes the sign of the dividend;
  - the sign fix-up is done within the final CALC cycle, so latency is unchanged;
  - most-negative / -1 returns quotient=most-negative, remainder=0, div_by_zero=0;
  - divide by zero returns quotient=all ones, remainder=dividend, div_by_zero=1.
REQ-035 When SEQ_DIVIDER_SIGNED_EN is not defined, all values SHALL be unsigned and no sign logic SHALL be synthesised.

Verification (WIDTH=8)
REQ-036 Unsigned 200/7, out_ready=1 -> quotient=28, remainder=4, div_by_zero=0; out_valid high exactly 9 edges after acceptance, for 1 cycle.
REQ-037 Unsigned 255/1, then 3/200 back-to-back -> results (255,0), then (0,3); in_ready is 0 throughout each operation.
REQ-038 Unsigned 5/0 -> quotient=255, remainder=5, div_by_zero=1; out_valid high 1 edge after acceptance.
REQ-039 Unsigned 100/9 with out_ready=0 for 6 cycles after out_valid rises -> (11,1) held stable and in_ready=0 throughout; IDLE after out_ready=1.
REQ-040 rst=1 on the 4th CALC cycle of 200/7 -> next cycle out_valid=0, in_ready=1, outputs 0; a following 50/5 returns (10,0).
REQ-041 With SEQ_DIVIDER_SIGNED_EN: -7/2 -> quotient=0xFD, remainder=0xFF; -128/-1 -> quotient=0x80, remainder=0.
